// File: rtl/mem_wb.sv
// -----------------------------------------------------------------------------
// mem_wb : memory stage plus MEM/WB pipeline register.
//
// This block holds a 64 x 32-bit data memory. The word address is
// F_in[7:2], so byte addresses wrap modulo 256. Each unstalled rising edge
// does two things:
//   - it performs an optional store (MW_in), and
//   - it registers the writeback data, write enable and write address
//     for the register file.
//
// Ports
//   CLOCK     in   1  rising-edge clock
//   RESET     in   1  asynchronous active-low reset (output regs only)
//   STALL     in   1  holds output registers, suppresses stores
//   RW_in     in   1  register-write request from EX
//   DA_in     in   5  destination register address from EX
//   MD_in     in   2  writeback select: 00/11 F_in, 01 mem word,
//                     10 less-than flag
//   MW_in     in   1  data-memory write request from EX
//   F_in      in  32  EX result / memory byte address
//   Data_in   in  32  store data
//   VxorN_in  in   1  EX less-than flag
//   BUS_D     out 32  registered writeback data
//   RW_out    out  1  registered register-file write enable
//   DA_out    out  5  registered register-file write address
//
// Configuration
//   MEM_WB_BYPASS_EN  When defined, a load and a store to the same word on
//                     the same edge return Data_in (write-first). When it
//                     is undefined (the default), they return the old
//                     word (read-first).
// -----------------------------------------------------------------------------
module mem_wb (
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic        STALL,
   input  logic        RW_in,
   input  logic [4:0]  DA_in,
   input  logic [1:0]  MD_in,
   input  logic        MW_in,
   input  logic [31:0] F_in,
   input  logic [31:0] Data_in,
   input  logic        VxorN_in,
   output logic [31:0] BUS_D,
   output logic        RW_out,
   output logic [4:0]  DA_out
);

   logic [31:0] mem [0:63];
   logic [5:0]  addr;
   logic        wr_en;
   logic [31:0] rd_word;
   logic [31:0] bus_d_nxt;
   logic        unused_f_bits;

   assign addr          = F_in[7:2];
   assign unused_f_bits = ^{F_in[31:8], F_in[1:0]};

   // RESET gates the store directly, so a store that is pending when reset
   // asserts is dropped. The memory array itself is never cleared.
   assign wr_en = RESET & ~STALL & MW_in;

   always_ff @(posedge CLOCK) begin
      if (wr_en)
         mem[addr] <= Data_in;
   end

   // The read word is captured into BUS_D on the same edge that samples the
   // address. This gives a synchronous read with one cycle of latency.
`ifdef MEM_WB_BYPASS_EN
   assign rd_word = MW_in ? Data_in : mem[addr];
`else
   assign rd_word = mem[addr];
`endif

   always_comb begin
      bus_d_nxt = F_in;
      case (MD_in)
         2'b01:   bus_d_nxt = rd_word;
         2'b10:   bus_d_nxt = {31'b0, VxorN_in};
         default: bus_d_nxt = F_in;
      endcase
   end

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         BUS_D  <= 32'h0;
         RW_out <= 1'b0;
         DA_out <= 5'h0;
      end else if (!STALL) begin
         BUS_D  <= bus_d_nxt;
         RW_out <= RW_in & (DA_in != 5'd0);   // r0 is hard-wired
         DA_out <= DA_in;
      end
   end

endmodule
